// File: rtl/clock_pkg.sv
// Shared constants for the clock display path: active-low segment patterns,
// field indices into the per-field blink enable, and the frame snapshot type.
package clock_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low {g,f,e,d,c,b,a} patterns; leftmost entry is digit 9.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam int FLD_SEC  = 0;
  localparam int FLD_MIN  = 1;
  localparam int FLD_HOUR = 2;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
    logic [2:0] blink_en;
    logic       dp_en;
  } snap_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low 7-segment pattern; A-F show a dash.
module bcd_to_seg
  import clock_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    if (bcd_i <= 4'd9) seg_o = SEG_DIGITS[bcd_i];
    else               seg_o = SEG_DASH;
  end

endmodule

// File: rtl/time_display_scan.sv
// Six-digit multiplexed HH.MM.SS display scanner with per-frame input snapshot,
// anti-ghosting slot blanking, per-field blinking and hour leading-zero blanking.
module time_display_scan
  import clock_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 2,
  parameter int BLINK_DIV   = 64,
  parameter int HOUR_LZB    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic [2:0] blink_en,
  input  logic       dp_en,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       dp,
  output logic       frame_tick
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);
  localparam logic [CW-1:0] CNT_MAX   = CW'(BLINK_DIV - 1);
  localparam logic [2:0]    LAST_IDX  = 3'd5;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  snap_t         snap_q, snap_d;
  logic [6:0]    seg_q, seg_d;
  logic [5:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          frame_tick_q;

  logic          frame_start;
  logic [3:0]    nib;
  logic [6:0]    dec_seg;
  logic          fld_blink, dp_slot, lzb_slot, blank;

  bcd_to_seg u_bcd_to_seg (
    .bcd_i (nib),
    .seg_o (dec_seg)
  );

  assign frame_start = (presc_q == '0) && (idx_q == '0);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
    end

    // Decode from the _d values so the first slot of a frame already sees
    // the fresh snapshot and blink phase.
    snap_d  = frame_start ? {hour, minute, second, blink_en, dp_en} : snap_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_start) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    nib       = 4'h0;
    fld_blink = 1'b0;
    dp_slot   = 1'b0;
    lzb_slot  = 1'b0;
    case (idx_q)
      3'd0: begin nib = snap_d.second[3:0]; fld_blink = snap_d.blink_en[FLD_SEC];  end
      3'd1: begin nib = snap_d.second[7:4]; fld_blink = snap_d.blink_en[FLD_SEC];  end
      3'd2: begin nib = snap_d.minute[3:0]; fld_blink = snap_d.blink_en[FLD_MIN];  dp_slot = 1'b1; end
      3'd3: begin nib = snap_d.minute[7:4]; fld_blink = snap_d.blink_en[FLD_MIN];  end
      3'd4: begin nib = snap_d.hour[3:0];   fld_blink = snap_d.blink_en[FLD_HOUR]; dp_slot = 1'b1; end
      3'd5: begin nib = snap_d.hour[7:4];   fld_blink = snap_d.blink_en[FLD_HOUR]; lzb_slot = 1'b1; end
      default: ;
    endcase

    blank = (phase_d && fld_blink) || (lzb_slot && (HOUR_LZB != 0) && (nib == 4'h0));
    seg_d = blank ? SEG_BLANK : dec_seg;
    dp_d  = ~(dp_slot && snap_d.dp_en && !blank);
    an_d  = (presc_q < BLANK_END) ? 6'h3F : ~(6'b1 << idx_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      snap_q       <= '0;
      seg_q        <= SEG_BLANK;
      an_q         <= 6'h3F;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      snap_q       <= snap_d;
      an_q         <= an_d;
      frame_tick_q <= frame_start;
      if (presc_q == '0) begin
        seg_q <= seg_d;
        dp_q  <= dp_d;
      end
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Directed self-checking bench for time_display_scan with a 4-cycle slot,
// 1 blank cycle, 2-frame blink half-period and hour leading-zero blanking.
module tb_time_display_scan;

  localparam int REFRESH_DIV = 4;
  localparam int BLANK_CYC   = 1;
  localparam int BLINK_DIV   = 2;
  localparam int HOUR_LZB    = 1;

  logic       clk;
  logic       reset;
  logic [7:0] hour, minute, second;
  logic [2:0] blink_en;
  logic       dp_en;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;
  logic       frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  time_display_scan #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYC   (BLANK_CYC),
    .BLINK_DIV   (BLINK_DIV),
    .HOUR_LZB    (HOUR_LZB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hour       (hour),
    .minute     (minute),
    .second     (second),
    .blink_en   (blink_en),
    .dp_en      (dp_en),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " seg"}, 32'(seg), 32'h7F);
    check({tag, " an"}, 32'(an), 32'h3F);
    check({tag, " dp"}, 32'(dp), 32'h1);
    check({tag, " frame_tick"}, 32'(frame_tick), 32'h0);
  endtask

  // One digit slot, sampled on falling edges: blank anodes first, then digit d.
  task automatic check_slot(input string tag, input int d, input logic [6:0] exp_seg,
                            input logic exp_dp);
    logic [5:0] an_on;
    an_on = ~(6'b1 << d);
    for (int c = 0; c < REFRESH_DIV; c++) begin
      @(negedge clk);
      check($sformatf("%s d%0d c%0d an", tag, d, c), 32'(an),
            32'((c < BLANK_CYC) ? 6'h3F : an_on));
      check($sformatf("%s d%0d c%0d seg", tag, d, c), 32'(seg), 32'(exp_seg));
      check($sformatf("%s d%0d c%0d dp", tag, d, c), 32'(dp), 32'(exp_dp));
      check($sformatf("%s d%0d c%0d frame_tick", tag, d, c), 32'(frame_tick),
            32'((c == 0) && (d == 0)));
    end
  endtask

  // segs packs {d5,...,d0} patterns; dps packs {d5,...,d0} decimal points.
  task automatic check_frame(input string tag, input logic [41:0] segs,
                             input logic [5:0] dps, input int lo, input int hi);
    for (int d = lo; d <= hi; d++) check_slot(tag, d, segs[d*7 +: 7], dps[d]);
  endtask

  initial begin
    reset    = 1'b0;
    hour     = 8'h99;
    minute   = 8'h77;
    second   = 8'h3C;
    blink_en = 3'b111;
    dp_en    = 1'b1;

    // 1: reset state, then release into 12:34:56.
    repeat (3) @(negedge clk);
    check_reset_state("reset_held");
    hour     = 8'h12;
    minute   = 8'h34;
    second   = 8'h56;
    blink_en = 3'b000;
    dp_en    = 1'b0;
    reset    = 1'b1;
    check_frame("f1_123456", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 6'h3F, 0, 5);

    // 2: hour leading-zero blank, then invalid hour ones nibble.
    hour = 8'h05;
    check_frame("f2_hour05", {7'h7F, 7'h12, 7'h30, 7'h19, 7'h12, 7'h02}, 6'h3F, 0, 5);
    hour = 8'h1A;
    check_frame("f3_hour1A", {7'h79, 7'h3F, 7'h30, 7'h19, 7'h12, 7'h02}, 6'h3F, 0, 5);

    // 3: mid-frame input change stays hidden until the next frame.
    hour   = 8'h12;
    second = 8'h59;
    check_frame("f4_pre", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h10}, 6'h3F, 0, 1);
    second = 8'h00;
    minute = 8'h00;
    check_frame("f4_post", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h10}, 6'h3F, 2, 5);
    check_frame("f5_new", {7'h79, 7'h24, 7'h40, 7'h40, 7'h40, 7'h40}, 6'h3F, 0, 5);

    // 4: minute blink with separators; phase is 1 in frames 6-7, 0 in 8-9.
    minute   = 8'h34;
    second   = 8'h56;
    blink_en = 3'b010;
    dp_en    = 1'b1;
    check_frame("f6_blank", {7'h79, 7'h24, 7'h7F, 7'h7F, 7'h12, 7'h02}, 6'h2F, 0, 5);
    check_frame("f7_blank", {7'h79, 7'h24, 7'h7F, 7'h7F, 7'h12, 7'h02}, 6'h2F, 0, 5);
    check_frame("f8_lit",   {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 6'h2B, 0, 5);
    check_frame("f9_lit",   {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 6'h2B, 0, 5);
    check_frame("f10_blank", {7'h79, 7'h24, 7'h7F, 7'h7F, 7'h12, 7'h02}, 6'h2F, 0, 2);

    // 5: reset while digit 3 is driven, then restart at digit 0 with phase 0.
    @(negedge clk);
    @(negedge clk);
    check("f10_d3_active an", 32'(an), 32'h37);
    reset = 1'b0;
    #1;
    check_reset_state("reset_mid");
    repeat (2) @(negedge clk);
    check_reset_state("reset_mid_held");
    reset = 1'b1;
    check_frame("post_reset_lit", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 6'h2B, 0, 5);
    check_frame("post_reset_blank", {7'h79, 7'h24, 7'h7F, 7'h7F, 7'h12, 7'h02}, 6'h2F, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
